// File: rtl/pe_filter_sched_db.sv
// PE-engine sequencer: ping-pong filter-bank loader plus core control and metadata
// alignment pipes between controller, filter buffer and conv core.
//
// state  | meaning
// IDLE   | no burst in flight, waiting for an empty bank and filter buffer data
// BURST  | issuing TIN consecutive filter reads into the target bank
module pe_filter_sched_db #(
  parameter int W_SIZE        = 9,
  parameter int W_CHANNEL     = 10,
  parameter int TIN           = 16,
  parameter int W_TIN         = 4,
  parameter int FILTER_BUF_AW = 12,
  parameter int IB_DELAY      = 2,
  parameter int PE_CAL_DELAY  = 11
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     c_ctrl_data_run,
  input  logic                     c_ctrl_csync_run,
  input  logic [W_SIZE-1:0]        c_row,
  input  logic [W_SIZE-1:0]        c_col,
  input  logic [W_CHANNEL-1:0]     c_chn,
  input  logic [W_CHANNEL-1:0]     c_chn_out,
  input  logic [5:0]               c_loc,
  input  logic [W_CHANNEL-1:0]     q_channel,
  input  logic                     fb_req_possible,
  output logic                     o_fb_req,
  output logic [FILTER_BUF_AW-1:0] o_fb_addr,
  output logic                     o_ld_vld,
  output logic                     o_ld_bank,
  output logic [W_TIN-1:0]         o_ld_idx,
  output logic                     o_core_data_run,
  output logic                     o_core_cal_start,
  output logic [3:0]               o_core_loc,
  output logic                     o_core_bank,
  output logic                     o_pe_csync_done,
  output logic                     o_underrun,
  output logic [W_SIZE-1:0]        o_meta_row,
  output logic [W_SIZE-1:0]        o_meta_col,
  output logic [W_CHANNEL-1:0]     o_meta_chn,
  output logic [W_CHANNEL-1:0]     o_meta_chn_out,
  output logic                     o_meta_first_chn,
  output logic                     o_meta_last_chn
);

  localparam int PRE = IB_DELAY + 2;
  localparam int STG = PRE + PE_CAL_DELAY;
  localparam int MW  = 2 * W_SIZE + 2 * W_CHANNEL;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [PRE-1:0]   dr_q;
  logic [3:0]       cloc_q  [PRE];
  logic [1:0]       cflag_q [STG];
  logic [MW-1:0]    meta_q  [STG];

  state_t           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [W_TIN-1:0] off_q, off_d;
  logic [W_CHANNEL-1:0] idx_q, idx_d;
  logic [1:0]       full_q, full_d;
  logic             ab_q, ab_d;
  logic             urun_q, urun_d;
  logic             csync_q;
  logic             ld_vld_q, ld_bank_q;
  logic [W_TIN-1:0] ld_idx_q;

  logic swap_ev, csync_start, last_beat;

  // Metadata and core-control pipes: free-running, never stalled or flushed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dr_q <= '0;
      for (int i = 0; i < PRE; i++) cloc_q[i] <= '0;
      for (int i = 0; i < STG; i++) begin
        cflag_q[i] <= '0;
        meta_q[i]  <= '0;
      end
    end else begin
      dr_q       <= {dr_q[PRE-2:0], c_ctrl_data_run};
      cloc_q[0]  <= c_loc[3:0];
      cflag_q[0] <= c_loc[5:4];
      meta_q[0]  <= {c_row, c_col, c_chn, c_chn_out};
      for (int i = 1; i < PRE; i++) cloc_q[i] <= cloc_q[i-1];
      for (int i = 1; i < STG; i++) begin
        cflag_q[i] <= cflag_q[i-1];
        meta_q[i]  <= meta_q[i-1];
      end
    end
  end

  // Bank swap is taken two stages before cal_start so the core sees the new bank on time.
  assign swap_ev     = dr_q[PRE-3] & cloc_q[PRE-3][2];
  assign csync_start = c_ctrl_csync_run & ~csync_q;
  assign last_beat   = (state_q == S_BURST) && (off_q == W_TIN'(TIN - 1));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    off_d   = off_q;
    idx_d   = idx_q;
    full_d  = full_q;
    ab_d    = ab_q;
    urun_d  = urun_q;
    case (state_q)
      S_IDLE: begin
        if (fb_req_possible && !(&full_q)) begin
          state_d = S_BURST;
          tgt_d   = full_q[ab_q] ? ~ab_q : ab_q;
          off_d   = '0;
        end
      end
      S_BURST: begin
        off_d = off_q + W_TIN'(1);
        if (last_beat) begin
          state_d       = S_IDLE;
          full_d[tgt_q] = 1'b1;
          idx_d = (idx_q == q_channel - W_CHANNEL'(1)) ? '0 : idx_q + W_CHANNEL'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A load finishing into the standby bank this same cycle counts as ready.
    if (swap_ev) begin
      if (!full_d[~ab_q]) urun_d = 1'b1;
      full_d[ab_q] = 1'b0;
      ab_d         = ~ab_q;
    end
    if (csync_start) begin
      state_d = S_IDLE;
      tgt_d   = 1'b0;
      off_d   = '0;
      idx_d   = '0;
      full_d  = '0;
      ab_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      tgt_q     <= 1'b0;
      off_q     <= '0;
      idx_q     <= '0;
      full_q    <= '0;
      ab_q      <= 1'b0;
      urun_q    <= 1'b0;
      csync_q   <= 1'b0;
      ld_vld_q  <= 1'b0;
      ld_bank_q <= 1'b0;
      ld_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      off_q     <= off_d;
      idx_q     <= idx_d;
      full_q    <= full_d;
      ab_q      <= ab_d;
      urun_q    <= urun_d;
      csync_q   <= c_ctrl_csync_run;
      ld_vld_q  <= o_fb_req;
      ld_bank_q <= tgt_q;
      ld_idx_q  <= off_q;
    end
  end

  assign o_fb_req         = (state_q == S_BURST);
  assign o_fb_addr        = FILTER_BUF_AW'({idx_q, off_q});
  assign o_ld_vld         = ld_vld_q;
  assign o_ld_bank        = ld_bank_q;
  assign o_ld_idx         = ld_idx_q;
  assign o_core_data_run  = dr_q[IB_DELAY-1];
  assign o_core_cal_start = dr_q[PRE-1];
  assign o_core_loc       = cloc_q[PRE-1];
  assign o_core_bank      = ab_q;
  assign o_pe_csync_done  = full_q[ab_q] & c_ctrl_csync_run;
  assign o_underrun       = urun_q;
  assign {o_meta_row, o_meta_col, o_meta_chn, o_meta_chn_out} = meta_q[STG-1];
  assign o_meta_last_chn  = cflag_q[STG-1][1];
  assign o_meta_first_chn = cflag_q[STG-1][0];

endmodule
